// File: rtl/oh_dsync_filt_pkg.sv
// Shared helpers for the oh_dsync_filt synchronizer/filter block.
package oh_dsync_filt_pkg;

    // Ceiling log2 for sizing counters from parameters at elaboration time.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/oh_dsync_filt_ch.sv
// One channel: PS-stage synchronizer (plus optional delay stage) and a
// persistence filter that only updates dout after FILT+1 mismatch cycles.
module oh_dsync_filt_ch
    import oh_dsync_filt_pkg::*;
#(
    parameter int unsigned PS     = 2,
    parameter int unsigned FILT   = 0,
    parameter logic        RSTVAL = 1'b0,
    parameter logic        DELAY  = 1'b0
) (
    input  logic clk,
    input  logic nreset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = (clog2(FILT + 1) > 1) ? clog2(FILT + 1) : 1;

    (* ASYNC_REG = "TRUE" *) logic [PS-1:0] sync_q;
    logic [PS-1:0] sync_d;
    logic          s;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          dout_q, dout_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    always_comb sync_d = {sync_q[PS-2:0], din};

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync_q <= {PS{RSTVAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    // Optional extra stage used to randomise CDC arrival in simulation.
    if (DELAY) begin : g_dly
        logic dly_q, dly_d;
        always_comb dly_d = sync_q[PS-1];
        always_ff @(posedge clk or negedge nreset) begin
            if (!nreset) begin
                dly_q <= RSTVAL;
            end else begin
                dly_q <= dly_d;
            end
        end
        assign s = dly_q;
    end else begin : g_nodly
        assign s = sync_q[PS-1];
    end

    // cnt never exceeds FILT, so the inequality test acts as the saturation limit.
    always_comb begin
        cnt_d  = cnt_q;
        dout_d = dout_q;
        if (s == dout_q) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(FILT)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            dout_d = s;
            cnt_d  = '0;
        end
        rise_d = dout_d & ~dout_q;
        fall_d = ~dout_d & dout_q;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt_q  <= '0;
            dout_q <= RSTVAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/oh_dsync_filt.sv
// N independent synchronize-and-filter channels with edge pulses and a
// combined change flag.
module oh_dsync_filt #(
    parameter int unsigned  N      = 1,
    parameter int unsigned  PS     = 2,
    parameter int unsigned  FILT   = 0,
    parameter logic [N-1:0] RSTVAL = '0,
    parameter logic [N-1:0] DELAY  = '0
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic         change
);

    for (genvar i = 0; i < N; i++) begin : g_ch
        oh_dsync_filt_ch #(
            .PS    (PS),
            .FILT  (FILT),
            .RSTVAL(RSTVAL[i]),
            .DELAY (DELAY[i])
        ) u_ch (
            .clk   (clk),
            .nreset(nreset),
            .din   (din[i]),
            .dout  (dout[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

    // Pure OR of the pulse registers; adds no latency.
    assign change = |{rise, fall};

endmodule

// File: tb/tb_oh_dsync_filt.sv
// Self-checking bench for oh_dsync_filt: window-based reference model feeding
// a scoreboard, plus scenario-specific latency and pulse-count checks.
module tb_oh_dsync_filt;

    localparam int unsigned N    = 4;
    localparam int unsigned PS   = 2;
    localparam int unsigned FILT = 3;
    localparam logic [3:0] RSTVAL = 4'b0101;
    localparam logic [3:0] DLY    = 4'b0100;

    logic       clk = 1'b0;
    logic       nreset = 1'b1;
    logic [3:0] din = 4'b1010;
    logic [3:0] dout, rise, fall;
    logic       change;
    logic [3:0] din_b = 4'b0000;
    logic [3:0] dout_b, rise_b, fall_b;
    logic       change_b;

    always #5 clk = ~clk;

    oh_dsync_filt #(.N(N), .PS(PS), .FILT(FILT), .RSTVAL(RSTVAL), .DELAY(4'b0000)) u_dut (
        .clk(clk), .nreset(nreset), .din(din),
        .dout(dout), .rise(rise), .fall(fall), .change(change)
    );

    oh_dsync_filt #(.N(N), .PS(PS), .FILT(0), .RSTVAL(4'b0000), .DELAY(DLY)) u_dut_b (
        .clk(clk), .nreset(nreset), .din(din_b),
        .dout(dout_b), .rise(rise_b), .fall(fall_b), .change(change_b)
    );

    typedef struct {
        logic [3:0] dout;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       change;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;

    // Reference: pipe of past din values, and a window of the last FILT+1 s values.
    logic [3:0] m_pipe [PS];
    logic [3:0] m_hist [FILT+1];
    logic [3:0] m_dout;

    task automatic model_reset();
        for (int j = 0; j < PS; j++) m_pipe[j] = RSTVAL;
        for (int j = 0; j <= FILT; j++) m_hist[j] = RSTVAL;
        m_dout = RSTVAL;
    endtask

    // Predict the outcome of the coming edge, push it, then advance to the next negedge.
    task automatic step();
        exp_t       e;
        logic [3:0] s, upd, nd;
        if (!nreset) begin
            model_reset();
            e.dout = RSTVAL; e.rise = 4'b0; e.fall = 4'b0; e.change = 1'b0;
        end else begin
            s = m_pipe[PS-1];
            for (int j = FILT; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = s;
            upd = 4'hF;
            for (int j = 0; j <= FILT; j++) upd = upd & (m_hist[j] ^ m_dout);
            nd = m_dout ^ upd;
            e.dout   = nd;
            e.rise   = nd & ~m_dout;
            e.fall   = ~nd & m_dout;
            e.change = |(e.rise | e.fall);
            m_dout   = nd;
            for (int j = PS - 1; j > 0; j--) m_pipe[j] = m_pipe[j-1];
            m_pipe[0] = din;
        end
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        exp_t e;
        nreset = 1'b0;
        din    = 4'b1010;
        @(negedge clk);
        model_reset();
        for (int k = 0; k < 2; k++) begin
            step();
            e = sb.pop_front();
            vectors++;
            if ({dout, rise, fall, change} !== {e.dout, e.rise, e.fall, e.change}) begin
                errors++;
                $display("FAIL reset_hold k=%0d: got dout=%b rise=%b fall=%b chg=%b, want %b %b %b %b",
                         k, dout, rise, fall, change, e.dout, e.rise, e.fall, e.change);
            end
        end
        vectors++;
        if (dout !== RSTVAL || rise !== 4'b0 || fall !== 4'b0 || change !== 1'b0) begin
            errors++;
            $display("FAIL reset_value: got dout=%b rise=%b fall=%b chg=%b, want 0101 0000 0000 0", dout, rise, fall, change);
        end
        nreset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            e = sb.pop_front();
            vectors++;
            if ({dout, rise, fall, change} !== {e.dout, e.rise, e.fall, e.change}) begin
                errors++;
                $display("FAIL reset_release k=%0d: got dout=%b rise=%b fall=%b chg=%b, want %b %b %b %b",
                         k, dout, rise, fall, change, e.dout, e.rise, e.fall, e.change);
            end
            vectors++;
            if (dout !== RSTVAL || change !== 1'b0) begin
                errors++;
                $display("FAIL reset_post k=%0d: got dout=%b chg=%b, want 0101 0", k, dout, change);
            end
        end
        // Settle every channel to 0 for the following scenarios.
        din = 4'b0000;
        for (int k = 0; k < 14; k++) begin
            step();
            e = sb.pop_front();
            vectors++;
            if ({dout, rise, fall, change} !== {e.dout, e.rise, e.fall, e.change}) begin
                errors++;
                $display("FAIL settle k=%0d: got dout=%b rise=%b fall=%b chg=%b, want %b %b %b %b",
                         k, dout, rise, fall, change, e.dout, e.rise, e.fall, e.change);
            end
        end
        vectors++;
        if (dout !== 4'b0000) begin
            errors++;
            $display("FAIL settle_final: got dout=%b, want 0000", dout);
        end
    endtask

    task automatic test_step();
        exp_t e;
        int   lat = -1;
        int   nrise = 0;
        din[1] = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            e = sb.pop_front();
            vectors++;
            if ({dout, rise, fall, change} !== {e.dout, e.rise, e.fall, e.change}) begin
                errors++;
                $display("FAIL step k=%0d: got dout=%b rise=%b fall=%b chg=%b, want %b %b %b %b",
                         k, dout, rise, fall, change, e.dout, e.rise, e.fall, e.change);
            end
            if (rise[1]) begin
                nrise++;
                if (lat < 0) lat = k;
                vectors++;
                if (change !== 1'b1 || dout[1] !== 1'b1) begin
                    errors++;
                    $display("FAIL step_pulse: got chg=%b dout1=%b with rise1, want 1 1", change, dout[1]);
                end
            end
        end
        vectors++;
        if (lat != 6) begin
            errors++;
            $display("FAIL step_latency: got %0d edges, want 6", lat);
        end
        vectors++;
        if (nrise != 1) begin
            errors++;
            $display("FAIL step_rise_count: got %0d, want 1", nrise);
        end
    endtask

    task automatic test_glitch();
        exp_t e;
        int   nrise = 0, nfall = 0, rise_at = -1, fall_at = -1;
        int   act3 = 0;
        for (int k = 0; k < 14; k++) begin
            din[3] = (k < 3) ? 1'b1 : 1'b0;
            step();
            e = sb.pop_front();
            vectors++;
            if ({dout, rise, fall, change} !== {e.dout, e.rise, e.fall, e.change}) begin
                errors++;
                $display("FAIL glitch3 k=%0d: got dout=%b rise=%b fall=%b chg=%b, want %b %b %b %b",
                         k, dout, rise, fall, change, e.dout, e.rise, e.fall, e.change);
            end
            if (dout[3] || rise[3] || fall[3]) act3++;
        end
        vectors++;
        if (act3 != 0) begin
            errors++;
            $display("FAIL glitch_short: got %0d active cycles on ch3, want 0", act3);
        end
        for (int k = 0; k < 18; k++) begin
            din[3] = (k < 4) ? 1'b1 : 1'b0;
            step();
            e = sb.pop_front();
            vectors++;
            if ({dout, rise, fall, change} !== {e.dout, e.rise, e.fall, e.change}) begin
                errors++;
                $display("FAIL glitch4 k=%0d: got dout=%b rise=%b fall=%b chg=%b, want %b %b %b %b",
                         k, dout, rise, fall, change, e.dout, e.rise, e.fall, e.change);
            end
            if (rise[3]) begin nrise++; rise_at = k; end
            if (fall[3]) begin nfall++; fall_at = k; end
        end
        vectors++;
        if (nrise != 1 || nfall != 1 || !(rise_at < fall_at)) begin
            errors++;
            $display("FAIL glitch_long: got rise=%0d@%0d fall=%0d@%0d, want one rise then one fall",
                     nrise, rise_at, nfall, fall_at);
        end
    endtask

    task automatic test_chatter();
        exp_t e;
        int   nrise = 0, nfall = 0;
        for (int k = 0; k < 32; k++) begin
            din[2] = (k >= 20) ? 1'b1 : ((k / 2) % 2 == 0);
            step();
            e = sb.pop_front();
            vectors++;
            if ({dout, rise, fall, change} !== {e.dout, e.rise, e.fall, e.change}) begin
                errors++;
                $display("FAIL chatter k=%0d: got dout=%b rise=%b fall=%b chg=%b, want %b %b %b %b",
                         k, dout, rise, fall, change, e.dout, e.rise, e.fall, e.change);
            end
            if (rise[2]) nrise++;
            if (fall[2]) nfall++;
        end
        vectors++;
        if (nrise != 1 || nfall != 0 || dout[2] !== 1'b1) begin
            errors++;
            $display("FAIL chatter_result: got rise=%0d fall=%0d dout2=%b, want 1 0 1", nrise, nfall, dout[2]);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   lat = -1, npulse = 0;
        din[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            e = sb.pop_front();
            vectors++;
            if ({dout, rise, fall, change} !== {e.dout, e.rise, e.fall, e.change}) begin
                errors++;
                $display("FAIL rmid_pre k=%0d: got dout=%b rise=%b fall=%b chg=%b, want %b %b %b %b",
                         k, dout, rise, fall, change, e.dout, e.rise, e.fall, e.change);
            end
        end
        nreset = 1'b0;
        #1;
        vectors++;
        if (dout !== RSTVAL || rise !== 4'b0 || fall !== 4'b0 || change !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async: got dout=%b rise=%b fall=%b chg=%b, want 0101 0000 0000 0", dout, rise, fall, change);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            step();
            e = sb.pop_front();
            vectors++;
            if ({dout, rise, fall, change} !== {e.dout, e.rise, e.fall, e.change}) begin
                errors++;
                $display("FAIL rmid_hold k=%0d: got dout=%b rise=%b fall=%b chg=%b, want %b %b %b %b",
                         k, dout, rise, fall, change, e.dout, e.rise, e.fall, e.change);
            end
        end
        nreset = 1'b1;
        din    = 4'b0111;
        for (int k = 1; k <= 9; k++) begin
            step();
            e = sb.pop_front();
            vectors++;
            if ({dout, rise, fall, change} !== {e.dout, e.rise, e.fall, e.change}) begin
                errors++;
                $display("FAIL rmid_post k=%0d: got dout=%b rise=%b fall=%b chg=%b, want %b %b %b %b",
                         k, dout, rise, fall, change, e.dout, e.rise, e.fall, e.change);
            end
            if (rise[1] || fall[1]) npulse++;
            if (dout[1] && lat < 0) lat = k;
        end
        vectors++;
        if (lat != 6 || npulse != 1) begin
            errors++;
            $display("FAIL rmid_relatch: got latency=%0d pulses=%0d, want 6 1", lat, npulse);
        end
    endtask

    task automatic test_delay();
        exp_t e;
        int   lat [4];
        int   cnt [4];
        int   want;
        for (int i = 0; i < 4; i++) begin lat[i] = -1; cnt[i] = 0; end
        din_b = 4'hF;
        for (int k = 1; k <= 7; k++) begin
            step();
            e = sb.pop_front();
            vectors++;
            if ({dout, rise, fall, change} !== {e.dout, e.rise, e.fall, e.change}) begin
                errors++;
                $display("FAIL delay_a k=%0d: got dout=%b rise=%b fall=%b chg=%b, want %b %b %b %b",
                         k, dout, rise, fall, change, e.dout, e.rise, e.fall, e.change);
            end
            for (int i = 0; i < 4; i++) begin
                if (rise_b[i]) begin
                    cnt[i]++;
                    if (lat[i] < 0) lat[i] = k;
                end
            end
            vectors++;
            if (change_b !== (k == 3 || k == 4)) begin
                errors++;
                $display("FAIL delay_change k=%0d: got %b, want %b", k, change_b, (k == 3 || k == 4));
            end
        end
        for (int i = 0; i < 4; i++) begin
            want = DLY[i] ? 4 : 3;
            vectors++;
            if (lat[i] != want || cnt[i] != 1) begin
                errors++;
                $display("FAIL delay_ch%0d: got latency=%0d pulses=%0d, want %0d 1", i, lat[i], cnt[i], want);
            end
        end
    endtask

    initial begin
        model_reset();
        #2;
        test_reset();
        test_step();
        test_glitch();
        test_chatter();
        test_reset_mid();
        test_delay();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
